// File: rtl/odd_parity.sv
// ============================================================================
// Module   : odd_parity
// Brief    : Odd-parity generator with a registered parity checker and a
//            saturating, clearable error counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module odd_parity #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   output logic             parity,
   input  logic             in_valid,
   input  logic             parity_in,
   input  logic             clear_cnt,
   output logic             parity_q,
   output logic             out_valid,
   output logic             err,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   logic             w_parity;
   logic             w_err;
   logic             r_parity_q;
   logic             r_out_valid;
   logic             r_err;
   logic [CNT_W-1:0] r_err_count;

   // A received word is good only when data plus its parity bit has odd weight.
   assign w_parity = ~(^data_in);
   assign w_err    = ~(^{data_in, parity_in});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_parity_q  <= 1'b0;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_parity_q <= w_parity;
            r_err      <= w_err;
         end
      end
   end

   // Clear wins over a same-edge increment; the count sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_count <= '0;
      end else if (clear_cnt) begin
         r_err_count <= '0;
      end else if (in_valid && w_err && (r_err_count != c_cnt_max)) begin
         r_err_count <= r_err_count + 1'b1;
      end
   end

   assign parity    = w_parity;
   assign parity_q  = r_parity_q;
   assign out_valid = r_out_valid;
   assign err       = r_err;
   assign err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_odd_parity.sv
// ============================================================================
// Module   : tb_odd_parity
// Brief    : Directed plus random self-checking bench for odd_parity, using a
//            weight-counting reference model and a CNT_W=2 saturation copy.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_odd_parity;

   logic        clk;
   logic        rst_n;
   logic [15:0] data_in;
   logic        in_valid;
   logic        parity_in;
   logic        clear_cnt;

   logic        parity,   parity_s;
   logic        parity_q, parity_q_s;
   logic        out_valid, out_valid_s;
   logic        err,      err_s;
   logic [15:0] err_count;
   logic [1:0]  err_count_s;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic m_pq, m_ov, m_err;
   int   m_cnt, m_cnt2;

   odd_parity #(.WIDTH(16), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .parity(parity),
      .in_valid(in_valid), .parity_in(parity_in), .clear_cnt(clear_cnt),
      .parity_q(parity_q), .out_valid(out_valid), .err(err), .err_count(err_count)
   );

   odd_parity #(.WIDTH(16), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .parity(parity_s),
      .in_valid(in_valid), .parity_in(parity_in), .clear_cnt(clear_cnt),
      .parity_q(parity_q_s), .out_valid(out_valid_s), .err(err_s), .err_count(err_count_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic ref_par(input logic [15:0] d);
      return (($countones(d) % 2) == 0);
   endfunction

   function automatic logic ref_err(input logic [15:0] d, input logic p);
      return ((($countones(d) + int'(p)) % 2) == 0);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_regs();
      check("out_valid",   64'(out_valid),   64'(m_ov));
      check("parity_q",    64'(parity_q),    64'(m_pq));
      check("err",         64'(err),         64'(m_err));
      check("err_count",   64'(err_count),   64'(m_cnt));
      check("err_count_s", 64'(err_count_s), 64'(m_cnt2));
   endtask

   task automatic model_reset();
      m_pq = 1'b0; m_ov = 1'b0; m_err = 1'b0; m_cnt = 0; m_cnt2 = 0;
   endtask

   // Applies one word, checks the comb output, then checks the registers after the edge.
   task automatic cycle(input logic v, input logic [15:0] d, input logic p, input logic c);
      in_valid = v; data_in = d; parity_in = p; clear_cnt = c;
      #1 check("parity", 64'(parity), 64'(ref_par(d)));
      @(posedge clk);
      if (c) begin
         m_cnt = 0; m_cnt2 = 0;
      end else if (v && ref_err(d, p)) begin
         m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
         m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
      end
      m_ov = v;
      if (v) begin
         m_pq  = ref_par(d);
         m_err = ref_err(d, p);
      end
      #1 check_regs();
   endtask

   logic [15:0] vec_d [8];
   logic        vec_p [8];

   initial begin
      vec_d = '{16'h576B, 16'h77EB, 16'hD56A, 16'h5D4A, 16'h9D6F, 16'h0000, 16'hFFFF, 16'h0001};
      vec_p = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

      rst_n = 1'b1; in_valid = 1'b0; data_in = '0; parity_in = 1'b0; clear_cnt = 1'b0;
      model_reset();
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_regs();
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // fixed combinational vectors, independent of the clock
      for (int i = 0; i < 8; i++) begin
         data_in = vec_d[i];
         #1 check("vec_parity", 64'(parity), 64'(vec_p[i]));
      end

      // check path: good word then bad word
      cycle(1'b1, 16'hD56A, 1'b0, 1'b0);
      check("d56a_err0", 64'(err), 64'd0);
      cycle(1'b1, 16'hD56A, 1'b1, 1'b0);
      check("d56a_err1", 64'(err), 64'd1);
      check("d56a_cnt1", 64'(err_count), 64'd1);

      // hold for three idle cycles
      repeat (3) cycle(1'b0, 16'h1234, 1'b0, 1'b0);

      // saturation of the 2-bit counter, then clear beating an increment
      cycle(1'b0, 16'h0000, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 16'hD56A, 1'b1, 1'b0);
         check("sat_seq", 64'(err_count_s), 64'((i < 3) ? i + 1 : 3));
      end
      cycle(1'b1, 16'hD56A, 1'b1, 1'b1);
      check("sat_clear", 64'(err_count_s), 64'd0);

      // asynchronous reset between edges with count 2 and out_valid high
      cycle(1'b1, 16'h0003, 1'b0, 1'b0);
      cycle(1'b1, 16'h0003, 1'b0, 1'b0);
      check("pre_rst_cnt", 64'(err_count), 64'd2);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_regs();
      data_in = 16'h0007;
      #1 check("rst_parity", 64'(parity), 64'(ref_par(16'h0007)));
      in_valid = 1'b1; parity_in = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_regs();
      in_valid = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1 check_regs();
      cycle(1'b1, 16'h00F0, 1'b0, 1'b0);
      check("post_rst_ov", 64'(out_valid), 64'd1);

      // random traffic against the reference model
      for (int i = 0; i < 10000; i++) begin
         cycle(($urandom % 8) != 0, 16'($urandom), 1'($urandom),
               ($urandom % 64) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
